lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store unit controller driving the data memory port from the pipeline's memory stage. Accepts one load or store request per handshake, and generates the data memory's `rd_en`/`wr_en`/mask/address/write-data signals. Splits misaligned accesses into multiple aligned memory beats. Returns sign- or zero-extended load data or an error on a single-cycle response strobe.

## Interface
- `MISALIGN_EN`, default 1: 1 = split misaligned accesses; 0 = report misaligned accesses as errors with no memory access.

- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32 size/sign code. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr` in `MEM_ADDR_WIDTH`: byte address.
- `req_wdata` in `REG_DATA_WIDTH`: store data, low bytes significant.
- `resp_valid` out 1: one-cycle completion strobe.
- `resp_rdata` out `REG_DATA_WIDTH`: extended load data; 0 for stores and errors.
- `resp_err` out 1: qualified by `resp_valid`.
- `mem_rd_en` out 1: to data memory.
- `mem_wr_en` out 1: to data memory.
- `mem_mask` out `MASK_WIDTH`: `MASK_W`/`MASK_H`/`MASK_B`.
- `mem_addr` out `MEM_ADDR_WIDTH`: to data memory.
- `mem_wr_data` out `REG_DATA_WIDTH`: to data memory.
- `mem_rd_data` in `REG_DATA_WIDTH`: combinational read result, valid in the same cycle as `mem_rd_en`/`mem_addr`; zero-extended for H/B.

## Operation
- **States:** IDLE, ACCESS, LD_LO, LD_HI, ST_BYTE, RESP.
- **Handshake:** `req_ready` = (state == IDLE). On `req_valid && req_ready`, capture `req_we`, `req_funct3`, `req_addr`, `req_wdata`.
- **Illegal request:** funct3 011/110/111, or a store with funct3[2]=1. Go to RESP with `resp_err`=1 and no memory beat.
- **Aligned request:** W with offset 0, H with addr[0]=0, any B.
  - Go to ACCESS, a single beat with mask from size and `mem_addr` = `req_addr`.
  - Loads capture `mem_rd_data` at the end of ACCESS.
  - Stores drive `req_wdata` unmodified; the memory selects the lane from addr[1:0].
- **Misaligned request, `MISALIGN_EN`=0:** RESP with error, no beat.
- **Misaligned load, `MISALIGN_EN`=1:**
  - LD_LO reads `MASK_W` at base = addr & ~3.
  - LD_HI reads `MASK_W` at base+4, wrapping modulo 2^`MEM_ADDR_WIDTH`.
  - Merge: result = ({hi,lo} >> 8*addr[1:0]), truncated to the access size.
- **Misaligned store, `MISALIGN_EN`=1:**
  - ST_BYTE issues N byte writes (N = 2 for H, 4 for W), one per cycle, with `MASK_B`.
  - `mem_addr` = addr+i (wrapping); `mem_wr_data[7:0]` = byte i of `req_wdata`, LSB first.
  - A 2-bit counter tracks i.
- **Extension:** B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
- **Memory port outside beats:** `mem_rd_en`, `mem_wr_en`, `mem_mask`, `mem_addr` and `mem_wr_data` are all 0 outside ACCESS/LD_*/ST_BYTE. `mem_rd_en` and `mem_wr_en` are never both high.

## Timing
- **Reset:** state IDLE, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, memory outputs 0.
- **Reset mid-operation:** abandons the request with no response. Bytes already written stay written; unissued bytes are never written.
- **Cycle numbering:** the acceptance edge is edge 0.
  - Aligned: beat in cycle 1, `resp_valid` in cycle 2.
  - Misaligned load: beats in cycles 1–2, response in cycle 3.
  - Misaligned store: beats in cycles 1..N, response in cycle N+1.
  - Error: response in cycle 1.
- **`resp_valid`:** high for exactly one cycle, in RESP. The next cycle is IDLE with `req_ready`=1. There is no back-to-back overlap; `req_valid` is ignored outside IDLE.
- **`resp_rdata`/`resp_err`:** registered; hold their values until the next response.

## Test plan
- **Aligned loads:** word at 0x10 = 0xDEADBEEF; LW 0x10. Expect cycle 1 `mem_rd_en`=1, `MASK_W`, addr 0x10. Expect cycle 2 `resp_valid`=1, rdata 0xDEADBEEF, err 0.
- **Extension:** word 0x80018000 at 0x10.
  - LB 0x13 → 0xFFFFFF80.
  - LBU 0x13 → 0x00000080.
  - LH 0x12 → 0xFFFF8001.
  - LHU 0x10 → 0x00008000.
- **Misaligned load:** 0x44332211 @0x10, 0x88776655 @0x14; LW 0x11. Expect reads of 0x10 then 0x14, and resp in cycle 3 = 0x55443322. LH 0x13 → 0x00005544.
- **Misaligned store:** SW 0xAABBCCDD at 0x13.
  - Expect byte writes 0x13=DD, 0x14=CC, 0x15=BB, 0x16=AA in cycles 1–4, resp in cycle 5 with err 0.
  - LW 0x14 readback has bytes [23:0] = 0xAABBCC.
- **Errors:**
  - funct3=011 → resp cycle 1 with err=1 and no mem enables.
  - `MISALIGN_EN`=0 with LH 0x11 → err=1, no beat.
  - Store with funct3=100 → err=1.
- **Reset mid-store:** assert `rst_n`=0 after 2 beats of the misaligned store. Expect no `resp_valid`, `req_ready`=1 after release, and only 0x13/0x14 modified.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_ctrl_if
//  Brief    : Request/response and data-memory bundle for the LSU controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface lsu_mem_ctrl_if #(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int REG_DATA_WIDTH = 32,
    parameter int MASK_WIDTH     = 2
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [2:0]                req_funct3;
    logic [MEM_ADDR_WIDTH-1:0] req_addr;
    logic [REG_DATA_WIDTH-1:0] req_wdata;
    logic                      resp_valid;
    logic [REG_DATA_WIDTH-1:0] resp_rdata;
    logic                      resp_err;
    logic                      mem_rd_en;
    logic                      mem_wr_en;
    logic [MASK_WIDTH-1:0]     mem_mask;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [REG_DATA_WIDTH-1:0] mem_wr_data;
    logic [REG_DATA_WIDTH-1:0] mem_rd_data;

    // Controller side: accepts requests, drives the data memory.
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_rd_en, mem_wr_en, mem_mask, mem_addr, mem_wr_data
    );

    // Pipeline and memory side.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_rd_en, mem_wr_en, mem_mask, mem_addr, mem_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_ctrl
//  Brief    : Load/store controller; splits misaligned accesses into beats.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
    parameter bit                    MISALIGN_EN    = 1'b1,
    parameter int                    MEM_ADDR_WIDTH = 32,
    parameter int                    REG_DATA_WIDTH = 32,
    parameter int                    MASK_WIDTH     = 2,
    parameter logic [MASK_WIDTH-1:0] MASK_B         = MASK_WIDTH'(1),
    parameter logic [MASK_WIDTH-1:0] MASK_H         = MASK_WIDTH'(2),
    parameter logic [MASK_WIDTH-1:0] MASK_W         = MASK_WIDTH'(3)
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_mem_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCESS  = 3'd1,
        ST_LD_LO   = 3'd2,
        ST_LD_HI   = 3'd3,
        ST_ST_BYTE = 3'd4,
        ST_RESP    = 3'd5
    } state_e;

    state_e                    state_q, state_d;
    logic                      we_q, we_d;
    logic [2:0]                f3_q, f3_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REG_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]                cnt_q, cnt_d;
    logic [REG_DATA_WIDTH-1:0] lo_q, lo_d;
    logic [REG_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;

    logic [MEM_ADDR_WIDTH-1:0]   w_base;
    logic [2*REG_DATA_WIDTH-1:0] w_merged;

    function automatic logic f_illegal(input logic we, input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    endfunction

    function automatic logic f_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b10) && (off != 2'b00)) || ((f3[1:0] == 2'b01) && off[0]);
    endfunction

    function automatic logic [MASK_WIDTH-1:0] f_mask(input logic [2:0] f3);
        logic [MASK_WIDTH-1:0] m;
        m = MASK_W;
        if (f3[1:0] == 2'b00) m = MASK_B;
        else if (f3[1:0] == 2'b01) m = MASK_H;
        return m;
    endfunction

    function automatic logic [REG_DATA_WIDTH-1:0] f_extend(input logic [2:0] f3,
                                                           input logic [REG_DATA_WIDTH-1:0] d);
        logic [REG_DATA_WIDTH-1:0] r;
        r = d;
        case (f3)
            3'b000:  r = {{(REG_DATA_WIDTH-8){d[7]}}, d[7:0]};
            3'b001:  r = {{(REG_DATA_WIDTH-16){d[15]}}, d[15:0]};
            3'b100:  r = {{(REG_DATA_WIDTH-8){1'b0}}, d[7:0]};
            3'b101:  r = {{(REG_DATA_WIDTH-16){1'b0}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    assign w_base   = {addr_q[MEM_ADDR_WIDTH-1:2], 2'b00};
    // High word above low word, shifted down by the byte offset of the access.
    assign w_merged = {bus.mem_rd_data, lo_q} >> {addr_q[1:0], 3'b000};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= 2'd0;
            lo_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        we_d            = we_q;
        f3_d            = f3_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        cnt_d           = cnt_q;
        lo_d            = lo_q;
        rdata_d         = rdata_q;
        err_d           = err_q;
        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.mem_rd_en   = 1'b0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_mask    = '0;
        bus.mem_addr    = '0;
        bus.mem_wr_data = '0;

        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    f3_d    = bus.req_funct3;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = 2'd0;
                    if (f_illegal(bus.req_we, bus.req_funct3) ||
                        (!MISALIGN_EN && f_misaligned(bus.req_funct3, bus.req_addr[1:0]))) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (f_misaligned(bus.req_funct3, bus.req_addr[1:0])) begin
                        state_d = bus.req_we ? ST_ST_BYTE : ST_LD_LO;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                bus.mem_rd_en   = !we_q;
                bus.mem_wr_en   = we_q;
                bus.mem_mask    = f_mask(f3_q);
                bus.mem_addr    = addr_q;
                bus.mem_wr_data = we_q ? wdata_q : '0;
                rdata_d         = we_q ? '0 : f_extend(f3_q, bus.mem_rd_data);
                err_d           = 1'b0;
                state_d         = ST_RESP;
            end
            ST_LD_LO: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_mask  = MASK_W;
                bus.mem_addr  = w_base;
                lo_d          = bus.mem_rd_data;
                state_d       = ST_LD_HI;
            end
            ST_LD_HI: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_mask  = MASK_W;
                bus.mem_addr  = w_base + MEM_ADDR_WIDTH'(4);
                rdata_d       = f_extend(f3_q, w_merged[REG_DATA_WIDTH-1:0]);
                err_d         = 1'b0;
                state_d       = ST_RESP;
            end
            ST_ST_BYTE: begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_mask    = MASK_B;
                bus.mem_addr    = addr_q + MEM_ADDR_WIDTH'(cnt_q);
                bus.mem_wr_data = {{(REG_DATA_WIDTH-8){1'b0}}, wdata_q[8*cnt_q +: 8]};
                // Word stores end on byte 3, halfword stores on byte 1.
                if (cnt_q == (f3_q[1] ? 2'd3 : 2'd1)) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_mem_ctrl
//  Brief    : Directed plus randomized bench with a byte-level memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

    localparam logic [1:0] MB  = 2'd1;
    localparam logic [1:0] MH  = 2'd2;
    localparam logic [1:0] MWD = 2'd3;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [1:0]  mask;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_word;

    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.MEM_ADDR_WIDTH(32), .REG_DATA_WIDTH(32), .MASK_WIDTH(2)) bus ();
    lsu_mem_ctrl_if #(.MEM_ADDR_WIDTH(32), .REG_DATA_WIDTH(32), .MASK_WIDTH(2)) bus0 ();

    lsu_mem_ctrl #(.MISALIGN_EN(1'b1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    lsu_mem_ctrl #(.MISALIGN_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    // Byte-addressed memory, aliased to 256 bytes; reads are combinational.
    wire [7:0] ma = bus.mem_addr[7:0];
    assign bus.mem_rd_data = !bus.mem_rd_en ? 32'h0 :
        (bus.mem_mask == MWD) ? {mem[ma+8'd3], mem[ma+8'd2], mem[ma+8'd1], mem[ma]} :
        (bus.mem_mask == MH)  ? {16'h0, mem[ma+8'd1], mem[ma]} : {24'h0, mem[ma]};
    assign bus0.mem_rd_data = bus0.mem_rd_en ? 32'hCAFEF00D : 32'h0;

    always @(posedge clk) begin
        if (pl_en)
            for (int i = 0; i < 4; i++) mem[8'(pl_addr + 8'(i))] <= pl_word[8*i +: 8];
        if (bus.mem_wr_en) begin
            for (int i = 0; i < ((bus.mem_mask == MWD) ? 4 : (bus.mem_mask == MH) ? 2 : 1); i++)
                mem[8'(ma + 8'(i))] <= bus.mem_wr_data[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a[7:0]; pl_word = w;
        for (int i = 0; i < 4; i++) ref_mem[8'(a + 32'(i))] = w[8*i +: 8];
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // Value of `size` bytes starting at `a`, then extended per funct3.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < size_of(f3); i++) v = v | (32'(ref_mem[8'(a + 32'(i))]) << (8*i));
        if (f3 == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
        if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] got_rdata);
        beat_t       exp_q[$];
        beat_t       b;
        int          n, exp_cyc, got_cyc;
        logic        ill, mis, exp_err;
        logic [31:0] exp_rd;
        n       = size_of(f3);
        ill     = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3 >= 3'd4);
        mis     = (a % n) != 0;
        exp_err = ill;
        exp_rd  = (ill || we) ? 32'h0 : model_load(f3, a);
        if (ill) begin
            exp_cyc = 1;
        end else if (!mis) begin
            exp_q.push_back('{!we, we, (n == 1) ? MB : (n == 2) ? MH : MWD, a, we ? wd : 32'h0});
            exp_cyc = 2;
        end else if (!we) begin
            exp_q.push_back('{1'b1, 1'b0, MWD, a & ~32'h3, 32'h0});
            exp_q.push_back('{1'b1, 1'b0, MWD, (a & ~32'h3) + 32'd4, 32'h0});
            exp_cyc = 3;
        end else begin
            for (int i = 0; i < n; i++)
                exp_q.push_back('{1'b0, 1'b1, MB, a + 32'(i), (wd >> (8*i)) & 32'hFF});
            exp_cyc = n + 1;
        end
        if (we && !ill)
            for (int i = 0; i < n; i++) ref_mem[8'(a + 32'(i))] = wd[8*i +: 8];

        @(negedge clk);
        chk("req_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = a; bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0; bus.req_we = 1'($urandom); bus.req_funct3 = 3'($urandom);
        bus.req_addr = $urandom; bus.req_wdata = $urandom;
        got_cyc = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            chk("rd_wr_excl", 32'(bus.mem_rd_en && bus.mem_wr_en), 32'd0);
            if (bus.mem_rd_en || bus.mem_wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 32'(cyc), 32'd0);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_ctl", {28'h0, bus.mem_rd_en, bus.mem_wr_en, bus.mem_mask},
                        {28'h0, b.rd, b.wr, b.mask});
                    chk("beat_addr", bus.mem_addr, b.addr);
                    chk("beat_data", bus.mem_wr_data, b.data);
                end
            end else begin
                chk("idle_port", {30'h0, bus.mem_mask} | bus.mem_addr | bus.mem_wr_data, 32'h0);
            end
            if (bus.resp_valid) begin
                got_cyc = cyc;
                break;
            end
        end
        got_rdata = bus.resp_rdata;
        chk("resp_cycle", 32'(got_cyc), 32'(exp_cyc));
        chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
        chk("resp_rdata", bus.resp_rdata, exp_rd);
        chk("beats_left", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("after_resp", {30'h0, bus.resp_valid, bus.req_ready}, 32'd1);
        chk("rdata_hold", bus.resp_rdata, exp_rd);
    endtask

    task automatic do_txn0(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic exp_err, input logic [31:0] exp_rd, input int exp_cyc);
        int beats, got_cyc;
        @(negedge clk);
        chk("req_ready0", 32'(bus0.req_ready), 32'd1);
        bus0.req_valid = 1'b1; bus0.req_we = we; bus0.req_funct3 = f3;
        bus0.req_addr = a; bus0.req_wdata = 32'h12345678;
        @(posedge clk);
        #1 bus0.req_valid = 1'b0;
        beats = 0; got_cyc = 0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (bus0.mem_rd_en || bus0.mem_wr_en) beats++;
            if (bus0.resp_valid) begin
                got_cyc = cyc;
                break;
            end
        end
        chk("resp_cycle0", 32'(got_cyc), 32'(exp_cyc));
        chk("resp_err0", 32'(bus0.resp_err), 32'(exp_err));
        chk("resp_rdata0", bus0.resp_rdata, exp_rd);
        chk("beats0", 32'(beats), exp_err ? 32'd0 : 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [2:0]  f3;
        rst_n = 1'b0; pl_en = 1'b0; pl_addr = 8'h0; pl_word = 32'h0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'h0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_funct3 = 3'h0;
        bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0;
        for (int k = 0; k < 64; k++) preload(32'(k * 4), $urandom);

        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp", {30'h0, bus.resp_valid, bus.resp_err}, 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'h0);
        chk("rst_mem", {28'h0, bus.mem_rd_en, bus.mem_wr_en, bus.mem_mask} | bus.mem_addr
                       | bus.mem_wr_data, 32'h0);
        rst_n = 1'b1;

        preload(32'h10, 32'hDEADBEEF);
        do_txn(1'b0, 3'b010, 32'h10, 32'h0, r);
        chk("lw_const", r, 32'hDEADBEEF);

        preload(32'h10, 32'h80018000);
        do_txn(1'b0, 3'b000, 32'h13, 32'h0, r); chk("lb_const",  r, 32'hFFFFFF80);
        do_txn(1'b0, 3'b100, 32'h13, 32'h0, r); chk("lbu_const", r, 32'h00000080);
        do_txn(1'b0, 3'b001, 32'h12, 32'h0, r); chk("lh_const",  r, 32'hFFFF8001);
        do_txn(1'b0, 3'b101, 32'h10, 32'h0, r); chk("lhu_const", r, 32'h00008000);

        preload(32'h10, 32'h44332211);
        preload(32'h14, 32'h88776655);
        do_txn(1'b0, 3'b010, 32'h11, 32'h0, r); chk("mis_lw_const", r, 32'h55443322);
        do_txn(1'b0, 3'b001, 32'h13, 32'h0, r); chk("mis_lh_const", r, 32'h00005544);

        do_txn(1'b1, 3'b010, 32'h13, 32'hAABBCCDD, r);
        do_txn(1'b0, 3'b010, 32'h14, 32'h0, r);
        chk("sw_readback", r & 32'h00FFFFFF, 32'h00AABBCC);

        do_txn(1'b0, 3'b011, 32'h10, 32'h0, r);
        do_txn(1'b1, 3'b100, 32'h10, 32'h55, r);
        do_txn(1'b1, 3'b101, 32'h12, 32'h55, r);
        do_txn(1'b0, 3'b111, 32'h10, 32'h0, r);

        do_txn(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, r);
        do_txn(1'b1, 3'b001, 32'hFFFFFFFF, 32'hBEEF, r);
        do_txn(1'b0, 3'b101, 32'hFFFFFFFF, 32'h0, r);
        chk("wrap_lhu_const", r, 32'h0000BEEF);

        do_txn0(1'b0, 3'b001, 32'h11, 1'b1, 32'h0, 1);
        do_txn0(1'b0, 3'b010, 32'h10, 1'b0, 32'hCAFEF00D, 2);
        do_txn0(1'b1, 3'b010, 32'h13, 1'b1, 32'h0, 1);
        do_txn0(1'b1, 3'b001, 32'h12, 1'b0, 32'h0, 2);

        // Reset lands on the edge that commits the second byte.
        preload(32'h10, 32'h44332211);
        preload(32'h14, 32'h88776655);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h13; bus.req_wdata = 32'h11223344;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_mid_quiet", {30'h0, bus.resp_valid, bus.mem_wr_en}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", {30'h0, bus.resp_valid, bus.req_ready}, 32'd1);
        chk("rst_mem13", 32'(mem[8'h13]), 32'h44);
        chk("rst_mem14", 32'(mem[8'h14]), 32'h33);
        chk("rst_mem15", 32'(mem[8'h15]), 32'h66);
        chk("rst_mem16", 32'(mem[8'h16]), 32'h77);
        ref_mem[8'h13] = 8'h44;
        ref_mem[8'h14] = 8'h33;
        do_txn(1'b0, 3'b010, 32'h14, 32'h0, r);
        chk("rst_readback", r, 32'h88776633);

        for (int k = 0; k < 200; k++) begin
            a  = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF8 | 32'($urandom_range(0, 7)))
                                             : $urandom;
            f3 = 3'($urandom_range(0, 7));
            do_txn(1'($urandom), f3, a, $urandom, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
